uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between N_REQ byte requesters. Arbitration is
//   round-robin at message granularity. Once a requester wins, it owns the
//   transmitter until the byte flagged "last" has finished, or until the
//   transmitter fails to go busy after a start.
//
// Handshake: a byte moves on a rising edge where i_req_valid[k] and
// o_req_ready[k] are both high. o_req_ready is combinational and at most one
// bit is set. Requesters must hold data/last stable while valid is high.
//
// Ports
//   clk            sole clock, rising edge
//   i_reset_n      asynchronous active-low reset
//   i_req_valid    per-requester byte valid            [N_REQ]
//   i_req_data     requester k byte at [k*DW +: DW]    [N_REQ*DW]
//   i_req_last     per-requester last-byte-of-message  [N_REQ]
//   o_req_ready    per-requester accept, one-hot or 0  [N_REQ]
//   o_tx_start     one-cycle start pulse to the transmitter
//   o_tx_data      byte for the transmitter, held until the next transfer
//   i_tx_busy      transmitter busy for the whole frame
//   o_grant_id     index of the current owner
//   o_locked       high in every state except IDLE
//   o_err_timeout  one-cycle pulse when busy never rose after a start
//   o_state_dbg    current FSM state encoding, for observation only
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                i_reset_n,
    input  logic [N_REQ-1:0]    i_req_valid,
    input  logic [N_REQ*DW-1:0] i_req_data,
    input  logic [N_REQ-1:0]    i_req_last,
    output logic [N_REQ-1:0]    o_req_ready,
    output logic                o_tx_start,
    output logic [DW-1:0]       o_tx_data,
    input  logic                i_tx_busy,
    output logic [2:0]          o_grant_id,
    output logic                o_locked,
    output logic                o_err_timeout,
    output logic [2:0]          o_state_dbg
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_LOCKED    = 3'd4
    } state_e;

    state_e          state_q;
    logic [2:0]      owner_q;
    logic [2:0]      last_grant_q;
    logic            last_flag_q;
    logic [CW-1:0]   cnt_q;
    logic [DW-1:0]   tx_data_q;
    logic            start_q;
    logic            err_q;
    logic            locked_q;

    logic            rr_found;
    logic [2:0]      rr_idx;
    logic [N_REQ-1:0] ready_v;
    logic [2:0]      xfer_idx;
    logic            xfer;
    logic [DW-1:0]   sel_data;
    logic            sel_last;

    // Round-robin search: walk the requesters starting just after the last
    // owner, wrapping modulo N_REQ, and take the first valid one.
    always_comb begin
        logic [3:0] cand;
        cand     = '0;
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = 4'(last_grant_q) + 4'(off);
            if (cand >= 4'(N_REQ)) begin
                cand = cand - 4'(N_REQ);
            end
            for (int k = 0; k < N_REQ; k++) begin
                if (!rr_found && (cand[2:0] == 3'(k)) && i_req_valid[k]) begin
                    rr_found = 1'b1;
                    rr_idx   = 3'(k);
                end
            end
        end
    end

    // Ready goes to the round-robin winner in IDLE, and only to the owner in
    // LOCKED (whether or not the owner is currently valid).
    always_comb begin
        ready_v  = '0;
        xfer_idx = owner_q;
        if (state_q == S_IDLE) begin
            xfer_idx = rr_idx;
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (state_q == S_IDLE) begin
                ready_v[k] = rr_found && (rr_idx == 3'(k));
            end else if (state_q == S_LOCKED) begin
                ready_v[k] = (owner_q == 3'(k));
            end
        end
    end

    assign xfer = |(ready_v & i_req_valid);

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (xfer_idx == 3'(k)) begin
                sel_data = i_req_data[k*DW +: DW];
                sel_last = i_req_last[k];
            end
        end
    end

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= S_IDLE;
            owner_q      <= '0;
            last_grant_q <= 3'(N_REQ - 1);
            last_flag_q  <= 1'b0;
            cnt_q        <= '0;
            tx_data_q    <= '0;
            start_q      <= 1'b0;
            err_q        <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            start_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE, S_LOCKED: begin
                    if (xfer) begin
                        tx_data_q   <= sel_data;
                        owner_q     <= xfer_idx;
                        last_flag_q <= sel_last;
                        start_q     <= 1'b1;
                        locked_q    <= 1'b1;
                        state_q     <= S_START;
                    end
                end
                S_START: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (i_tx_busy) begin
                        state_q <= S_WAIT_DONE;
                    end else if (cnt_q == CW'(TIMEOUT - 2)) begin
                        // The counter would reach TIMEOUT-1 on this edge, so
                        // the error pulse lands TIMEOUT cycles after the start.
                        err_q        <= 1'b1;
                        last_grant_q <= owner_q;
                        locked_q     <= 1'b0;
                        state_q      <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        if (last_flag_q) begin
                            last_grant_q <= owner_q;
                            locked_q     <= 1'b0;
                            state_q      <= S_IDLE;
                        end else begin
                            state_q <= S_LOCKED;
                        end
                    end
                end
                default: begin
                    locked_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready   = ready_v;
    assign o_tx_start    = start_q;
    assign o_tx_data     = tx_data_q;
    assign o_grant_id    = owner_q;
    assign o_locked      = locked_q;
    assign o_err_timeout = err_q;
    assign o_state_dbg   = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter. Requesters are modelled as per-requester
// byte queues; a transmitter model raises busy when it sees a start pulse.
// Expected grant order is derived from the queues by message-level
// round-robin and checked against every start pulse.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            i_reset_n;
    logic [N-1:0]    i_req_valid;
    logic [N*DW-1:0] i_req_data;
    logic [N-1:0]    i_req_last;
    logic            i_tx_busy;
    logic [N-1:0]    o_req_ready;
    logic            o_tx_start;
    logic [DW-1:0]   o_tx_data;
    logic [2:0]      o_grant_id;
    logic            o_locked;
    logic            o_err_timeout;
    logic [2:0]      o_state_dbg;

    uart_tx_arbiter #(.N_REQ(N), .DW(DW), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .i_reset_n     (i_reset_n),
        .i_req_valid   (i_req_valid),
        .i_req_data    (i_req_data),
        .i_req_last    (i_req_last),
        .o_req_ready   (o_req_ready),
        .o_tx_start    (o_tx_start),
        .o_tx_data     (o_tx_data),
        .i_tx_busy     (i_tx_busy),
        .o_grant_id    (o_grant_id),
        .o_locked      (o_locked),
        .o_err_timeout (o_err_timeout),
        .o_state_dbg   (o_state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    // requester queues: {last, data}
    logic [8:0]  rq [N][$];
    // scoreboard: {grant_id, data} for each expected start
    logic [10:0] exp_q [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_cnt = 0;
    int busy_len = 10;
    bit never_busy = 1'b0;
    bit rand_busy = 1'b0;
    logic [N-1:0] hs = '0;
    bit busy_prev = 1'b0;
    bit hold_on = 1'b0;
    logic [7:0] hold_exp = '0;
    int model_last = N - 1;
    int start_cyc [$];
    int start_id [$];
    int fall_cyc [$];
    int err_cyc [$];
    int first_ready [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        start_cyc.delete();
        start_id.delete();
        fall_cyc.delete();
        err_cyc.delete();
        for (int k = 0; k < N; k++) first_ready[k] = -1;
    endtask

    // Message-level round-robin over the loaded queues.
    task automatic build_model();
        logic [8:0] mq [N][$];
        logic [8:0] item;
        int k;
        bit found;
        for (int j = 0; j < N; j++) mq[j] = rq[j];
        forever begin
            found = 1'b0;
            k = 0;
            for (int off = 1; off <= N; off++) begin
                if (!found && mq[(model_last + off) % N].size() > 0) begin
                    found = 1'b1;
                    k = (model_last + off) % N;
                end
            end
            if (!found) break;
            do begin
                item = mq[k].pop_front();
                exp_q.push_back({3'(k), item[7:0]});
            end while (!item[8] && mq[k].size() > 0);
            model_last = k;
        end
    endtask

    task automatic drive();
        logic [8:0] item;
        i_req_valid = '0;
        i_req_last  = '0;
        i_req_data  = '0;
        for (int k = 0; k < N; k++) begin
            if (rq[k].size() > 0) begin
                item = rq[k][0];
                i_req_valid[k] = 1'b1;
                i_req_last[k]  = item[8];
                i_req_data[k*DW +: DW] = item[7:0];
            end
        end
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        for (int k = 0; k < N; k++) rq[k].delete();
        exp_q.delete();
        drive();
        i_tx_busy = 1'b0;
        busy_cnt = 0;
        hs = '0;
        busy_prev = 1'b0;
        hold_on = 1'b0;
        model_last = N - 1;
        clear_logs();
        @(negedge clk); #1;
        chk("rst_tx_start", o_tx_start, 0);
        chk("rst_tx_data", o_tx_data, 0);
        chk("rst_grant_id", o_grant_id, 0);
        chk("rst_locked", o_locked, 0);
        chk("rst_err", o_err_timeout, 0);
        chk("rst_ready", o_req_ready, 0);
        @(negedge clk); #1;
        i_reset_n = 1'b1;
    endtask

    // One cycle per iteration: transmitter model and requester pops at the
    // falling edge, then DUT outputs sampled 1ns later.
    task automatic run(input int n, input bit until_done);
        logic [10:0] e;
        logic [31:0] oh;
        int i;
        i = 0;
        while (i < n) begin
            @(negedge clk);
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) i_tx_busy = 1'b0;
            end
            if (o_tx_start && !never_busy) begin
                i_tx_busy = 1'b1;
                busy_cnt = rand_busy ? $urandom_range(2, 6) : busy_len;
            end
            for (int k = 0; k < N; k++) begin
                if (hs[k] && rq[k].size() > 0) void'(rq[k].pop_front());
            end
            drive();
            #1;
            cyc++;
            chk("ready_onehot0", 32'($onehot0(o_req_ready)), 1);
            if (o_tx_start) begin
                start_cyc.push_back(cyc);
                start_id.push_back(int'(o_grant_id));
                chk("ready_in_start", o_req_ready, 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_start", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant_id", o_grant_id, e[10:8]);
                    chk("tx_data", o_tx_data, e[7:0]);
                    hold_exp = e[7:0];
                    hold_on = 1'b1;
                end
            end
            if (hold_on) chk("tx_data_hold", o_tx_data, hold_exp);
            if (i_tx_busy) chk("ready_while_busy", o_req_ready, 0);
            if (busy_prev && !i_tx_busy) begin
                fall_cyc.push_back(cyc);
                hold_on = 1'b0;
            end
            busy_prev = i_tx_busy;
            if (o_err_timeout) begin
                err_cyc.push_back(cyc);
                chk("timeout_locked", o_locked, 0);
                chk("timeout_idle", o_state_dbg, 0);
                hold_on = 1'b0;
            end
            for (int k = 0; k < N; k++) begin
                if (o_req_ready[k] && first_ready[k] < 0) first_ready[k] = cyc;
            end
            hs = i_req_valid & o_req_ready;
            if (hs != '0) begin
                if (exp_q.size() > 0) begin
                    e = exp_q[0];
                    oh = 32'd1 << e[10:8];
                    chk("grant_select", 32'(hs), oh);
                end else begin
                    chk("spurious_transfer", 32'(hs), 0);
                end
            end
            i++;
            if (until_done && exp_q.size() == 0 && !o_locked && !i_tx_busy) break;
        end
        if (until_done) chk("run_budget", exp_q.size(), 0);
    endtask

    int exp_ord [5] = '{0, 1, 2, 3, 0};

    initial begin
        i_reset_n = 1'b0;
        i_tx_busy = 1'b0;
        drive();

        // Two single-byte messages from requesters 0 and 2, busy 10 cycles.
        do_reset();
        rq[0].push_back({1'b1, 8'hA5});
        rq[2].push_back({1'b1, 8'h3C});
        build_model();
        run(200, 1'b1);
        chk("rr_nstarts", start_id.size(), 2);
        if (start_id.size() == 2) begin
            chk("rr_first", start_id[0], 0);
            chk("rr_second", start_id[1], 2);
            chk("start_gap", start_cyc[1] - start_cyc[0], 12);
        end

        // Requester 1 three-byte message while requester 3 waits.
        do_reset();
        rq[1].push_back({1'b0, 8'h11});
        rq[1].push_back({1'b0, 8'h22});
        rq[1].push_back({1'b1, 8'h33});
        rq[3].push_back({1'b1, 8'h44});
        build_model();
        run(300, 1'b1);
        chk("lock_nstarts", start_id.size(), 4);
        if (start_id.size() == 4) begin
            chk("lock_id0", start_id[0], 1);
            chk("lock_id1", start_id[1], 1);
            chk("lock_id2", start_id[2], 1);
            chk("lock_id3", start_id[3], 3);
        end
        if (fall_cyc.size() >= 3) begin
            chk("req3_ready_after_fall", first_ready[3], fall_cyc[2] + 1);
        end else begin
            chk("lock_nfalls", fall_cyc.size(), 3);
        end

        // All four valid continuously with single-byte messages.
        do_reset();
        for (int k = 0; k < N; k++) begin
            for (int m = 0; m < 2; m++) rq[k].push_back({1'b1, 8'(k * 16 + m + 1)});
        end
        build_model();
        run(600, 1'b1);
        for (int j = 0; j < 5; j++) begin
            if (start_id.size() > j) chk("rr_order", start_id[j], exp_ord[j]);
            else chk("rr_order_missing", j, start_id.size());
        end

        // Transmitter never goes busy.
        do_reset();
        never_busy = 1'b1;
        rq[0].push_back({1'b1, 8'h5A});
        build_model();
        run(100, 1'b1);
        chk("timeout_npulses", err_cyc.size(), 1);
        if (err_cyc.size() == 1 && start_cyc.size() == 1) begin
            chk("timeout_delay", err_cyc[0] - start_cyc[0], TO);
        end
        // After the timeout the owner counts as last grant, so 1 beats 0.
        clear_logs();
        rq[0].push_back({1'b1, 8'h66});
        rq[1].push_back({1'b1, 8'h77});
        build_model();
        run(200, 1'b1);
        if (start_id.size() > 0) chk("post_timeout_grant", start_id[0], 1);
        else chk("post_timeout_nstarts", start_id.size(), 2);
        chk("post_timeout_npulses", err_cyc.size(), 2);
        never_busy = 1'b0;

        // Reset asserted while waiting for busy to fall.
        do_reset();
        rq[1].push_back({1'b0, 8'h81});
        rq[1].push_back({1'b0, 8'h82});
        rq[1].push_back({1'b1, 8'h83});
        build_model();
        run(6, 1'b0);
        chk("pre_reset_locked", o_locked, 1);
        i_reset_n = 1'b0;
        #1;
        chk("async_rst_start", o_tx_start, 0);
        chk("async_rst_locked", o_locked, 0);
        chk("async_rst_grant", o_grant_id, 0);
        chk("async_rst_data", o_tx_data, 0);
        do_reset();
        rq[0].push_back({1'b1, 8'h90});
        rq[1].push_back({1'b1, 8'h91});
        build_model();
        run(200, 1'b1);
        if (start_id.size() > 0) chk("post_reset_grant", start_id[0], 0);
        else chk("post_reset_nstarts", start_id.size(), 2);

        // Randomized traffic with random busy lengths.
        rand_busy = 1'b1;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            for (int k = 0; k < N; k++) begin
                int nm;
                nm = $urandom_range(0, 3);
                for (int m = 0; m < nm; m++) begin
                    int nb;
                    nb = $urandom_range(1, 3);
                    for (int b = 0; b < nb; b++) begin
                        rq[k].push_back({(b == nb - 1), 8'($urandom)});
                    end
                end
            end
            if (rq[0].size() == 0) rq[0].push_back({1'b1, 8'($urandom)});
            build_model();
            run(4000, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
